// File: rtl/player_sprite_engine_if.sv
// rtl/player_sprite_engine_if.sv - control/pixel bundle between sprite driver and player sprite engine
//
// Purpose: groups the per-pixel beam inputs, register writes and the pixel
// output of the player sprite engine so a driver (master) and the engine
// (slave) connect through one port.
// Signals:
//   pixel_en       advance one pixel this cycle
//   hpos           current beam column, valid when pixel_en=1
//   graphics_load  write graphics_in to the new graphics buffer
//   graphics_in    sprite line data
//   vdelay_swap    copy the new graphics buffer into the old one
//   vdelay         1: display old buffer, 0: display new buffer
//   position_load  load position_in as the absolute column
//   position_in    absolute column (ignored when off the visible line)
//   strobe         load the current hpos as the position
//   scale          clocks per sprite bit: 1x/2x/4x/8x
//   reflect        0: MSB first, 1: LSB first
//   copies         0: one, 1: +close, 2: +medium, 3: +close +medium
//   value          current sprite pixel
//   active         serializer running
interface player_sprite_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int POS_WIDTH  = 8
);
  logic                  pixel_en;
  logic [POS_WIDTH-1:0]  hpos;
  logic                  graphics_load;
  logic [DATA_WIDTH-1:0] graphics_in;
  logic                  vdelay_swap;
  logic                  vdelay;
  logic                  position_load;
  logic [POS_WIDTH-1:0]  position_in;
  logic                  strobe;
  logic [1:0]            scale;
  logic                  reflect;
  logic [1:0]            copies;
  logic                  value;
  logic                  active;

  modport master (
    output pixel_en, hpos, graphics_load, graphics_in, vdelay_swap, vdelay,
           position_load, position_in, strobe, scale, reflect, copies,
    input  value, active
  );

  modport slave (
    input  pixel_en, hpos, graphics_load, graphics_in, vdelay_swap, vdelay,
           position_load, position_in, strobe, scale, reflect, copies,
    output value, active
  );
endinterface

// File: rtl/player_sprite_engine.sv
// rtl/player_sprite_engine.sv - player sprite serializer with copies, scaling, reflection and vertical delay
//
// Purpose: holds the sprite column and double-buffered graphics, triggers on
// the beam column (up to three copies) and shifts the graphics out one bit per
// 1/2/4/8 pixel clocks.
// Ports:
//   clk    pixel-domain clock
//   reset  synchronous, active-high
//   bus    slave side of player_sprite_engine_if (beam, register writes,
//          display controls in; value/active out)
module player_sprite_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int POS_WIDTH   = 8,
  parameter int LINE_PIXELS = 160,
  parameter int COPY_CLOSE  = 16,
  parameter int COPY_MEDIUM = 32
) (
  input logic                   clk,
  input logic                   reset,
  player_sprite_engine_if.slave bus
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [POS_WIDTH:0] LINE_W   = (POS_WIDTH+1)'(LINE_PIXELS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [POS_WIDTH-1:0]  pos_q, pos_d;
  logic [DATA_WIDTH-1:0] gfx_new_q, gfx_new_d;
  logic [DATA_WIDTH-1:0] gfx_old_q, gfx_old_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [2:0]            sub_cnt_q, sub_cnt_d;

  // Copy column = base + offset, folded back onto the visible line.
  function automatic logic [POS_WIDTH-1:0] wrap_col(input logic [POS_WIDTH-1:0] base,
                                                    input int                   off);
    logic [POS_WIDTH:0] sum;
    sum = {1'b0, base} + (POS_WIDTH+1)'(off);
    if (sum >= LINE_W) sum = sum - LINE_W;
    return sum[POS_WIDTH-1:0];
  endfunction

  logic [POS_WIDTH-1:0]  col_close, col_medium;
  logic                  hit, trigger;
  logic [2:0]            sub_limit;
  logic [DATA_WIDTH-1:0] gfx;
  logic [IDX_W-1:0]      bit_sel;

  assign col_close  = wrap_col(pos_q, COPY_CLOSE);
  assign col_medium = wrap_col(pos_q, COPY_MEDIUM);
  assign hit        = (bus.hpos == pos_q)
                    | (bus.copies[0] & (bus.hpos == col_close))
                    | (bus.copies[1] & (bus.hpos == col_medium));
  assign trigger    = bus.pixel_en & hit;

  always_comb begin
    sub_limit = 3'd0;
    case (bus.scale)
      2'd0: sub_limit = 3'd0;
      2'd1: sub_limit = 3'd1;
      2'd2: sub_limit = 3'd3;
      2'd3: sub_limit = 3'd7;
      default: sub_limit = 3'd0;
    endcase
  end

  // Graphics are read live so mid-sprite writes show on the next bit.
  assign gfx       = bus.vdelay ? gfx_old_q : gfx_new_q;
  assign bit_sel   = bus.reflect ? bit_idx_q : (LAST_IDX - bit_idx_q);
  assign bus.active = (state_q == RUN);
  assign bus.value  = (state_q == RUN) & gfx[bit_sel];

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    gfx_new_d = gfx_new_q;
    gfx_old_d = gfx_old_q;
    bit_idx_d = bit_idx_q;
    sub_cnt_d = sub_cnt_q;

    // A same-cycle load and swap moves the previous new graphics into old.
    if (bus.graphics_load) gfx_new_d = bus.graphics_in;
    if (bus.vdelay_swap)   gfx_old_d = gfx_new_q;

    if (bus.pixel_en && bus.strobe) begin
      pos_d = bus.hpos;
    end else if (bus.position_load && ({1'b0, bus.position_in} < LINE_W)) begin
      pos_d = bus.position_in;
    end

    // Restart has priority over end-of-sprite.
    if (trigger) begin
      state_d   = RUN;
      bit_idx_d = '0;
      sub_cnt_d = '0;
    end else if (bus.pixel_en && (state_q == RUN)) begin
      // >= so a count stranded above a newly reduced limit wraps next pixel.
      if (sub_cnt_q >= sub_limit) begin
        sub_cnt_d = '0;
        if (bit_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          bit_idx_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end else begin
        sub_cnt_d = sub_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      gfx_new_q <= '0;
      gfx_old_q <= '0;
      bit_idx_q <= '0;
      sub_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      gfx_new_q <= gfx_new_d;
      gfx_old_q <= gfx_old_d;
      bit_idx_q <= bit_idx_d;
      sub_cnt_q <= sub_cnt_d;
    end
  end

endmodule

// File: tb/tb_player_sprite_engine.sv
// tb/tb_player_sprite_engine.sv - self-checking bench for player_sprite_engine
module tb_player_sprite_engine;

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  player_sprite_engine_if #(.DATA_WIDTH(8), .POS_WIDTH(8)) bus ();

  player_sprite_engine #(
    .DATA_WIDTH(8), .POS_WIDTH(8), .LINE_PIXELS(160),
    .COPY_CLOSE(16), .COPY_MEDIUM(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a sprite is "pixels elapsed since the last trigger";
  // the displayed bit is elapsed / (1<<scale), counted from MSB or LSB.
  int         m_pos = 0;
  logic [7:0] m_new = 8'h00;
  logic [7:0] m_old = 8'h00;
  bit         m_run = 1'b0;
  int         m_el  = 0;

  task automatic model_step();
    bit trig;
    int p;
    p = m_pos;
    if (reset) begin
      m_pos = 0; m_new = 8'h00; m_old = 8'h00; m_run = 1'b0; m_el = 0;
      return;
    end
    if (bus.vdelay_swap)   m_old = m_new;
    if (bus.graphics_load) m_new = bus.graphics_in;
    if (bus.pixel_en && bus.strobe) m_pos = int'(bus.hpos);
    else if (bus.position_load && int'(bus.position_in) < 160) m_pos = int'(bus.position_in);
    trig = bus.pixel_en && ((int'(bus.hpos) == p) ||
           (bus.copies[0] && int'(bus.hpos) == (p + 16) % 160) ||
           (bus.copies[1] && int'(bus.hpos) == (p + 32) % 160));
    if (trig) begin
      m_run = 1'b1; m_el = 0;
    end else if (bus.pixel_en && m_run) begin
      m_el++;
      if (m_el == (8 << bus.scale)) m_run = 1'b0;
    end
  endtask

  function automatic logic model_value();
    logic [7:0] g;
    int idx;
    g   = bus.vdelay ? m_old : m_new;
    idx = m_el >> bus.scale;
    if (!m_run) return 1'b0;
    return bus.reflect ? g[idx] : g[7 - idx];
  endfunction

  // Inputs only change on the falling edge, so the model sees the same
  // values at the rising edge as the design does.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("value", bus.value, model_value());
      check("active", bus.active, m_run);
    end
  end

  task automatic cyc(input bit pe, input int h);
    @(negedge clk);
    reset             = 1'b0;
    bus.pixel_en      = pe;
    bus.hpos          = 8'(h);
    bus.graphics_load = 1'b0;
    bus.vdelay_swap   = 1'b0;
    bus.position_load = 1'b0;
    bus.strobe        = 1'b0;
  endtask

  task automatic load_gfx(input logic [7:0] g, input bit swap);
    cyc(0, 0);
    bus.graphics_load = 1'b1;
    bus.graphics_in   = g;
    bus.vdelay_swap   = swap;
  endtask

  task automatic swap_only();
    cyc(0, 0);
    bus.vdelay_swap = 1'b1;
  endtask

  task automatic set_pos(input int p);
    cyc(0, 0);
    bus.position_load = 1'b1;
    bus.position_in   = 8'(p);
  endtask

  int ones[$];
  int act_cnt;

  // One full line of columns 0..159; records the columns where value is high.
  task automatic run_line(input int strobe_at);
    ones.delete();
    act_cnt = 0;
    for (int h = 0; h < 160; h++) begin
      cyc(1, h);
      if (h == strobe_at) bus.strobe = 1'b1;
      if (bus.value)  ones.push_back(h);
      if (bus.active) act_cnt++;
    end
    cyc(0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.pixel_en = 1'b0; bus.hpos = '0; bus.graphics_load = 1'b0;
    bus.graphics_in = '0; bus.vdelay_swap = 1'b0; bus.vdelay = 1'b0;
    bus.position_load = 1'b0; bus.position_in = '0; bus.strobe = 1'b0;
    bus.scale = 2'd0; bus.reflect = 1'b0; bus.copies = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_value", bus.value, 0);
    check("rst_active", bus.active, 0);

    // 1x, one copy at column 10
    set_pos(10);
    load_gfx(8'b1000_0001, 0);
    run_line(-1);
    check("t1_ones", ones.size(), 2);
    check("t1_first", ones[0], 11);
    check("t1_last", ones[ones.size()-1], 18);
    check("t1_active", act_cnt, 8);

    // 8x
    bus.scale = 2'd3;
    run_line(-1);
    check("t2_ones", ones.size(), 16);
    check("t2_first", ones[0], 11);
    check("t2_mid", ones[8], 67);
    check("t2_last", ones[15], 74);
    check("t2_active", act_cnt, 64);

    // reflect
    bus.scale = 2'd0;
    bus.reflect = 1'b1;
    load_gfx(8'b1100_0000, 0);
    run_line(-1);
    check("t3_ones", ones.size(), 2);
    check("t3_first", ones[0], 17);

    // three copies with wrap
    bus.reflect = 1'b0;
    bus.copies = 2'd3;
    set_pos(150);
    load_gfx(8'b1000_0001, 0);
    run_line(-1);
    check("t4_ones", ones.size(), 6);
    check("t4_c1", ones[0], 7);
    check("t4_c2", ones[2], 23);
    check("t4_c0", ones[4], 151);

    // retrigger at column 26 while an 8x sprite from column 10 is running
    bus.copies = 2'd1;
    bus.scale = 2'd3;
    set_pos(10);
    run_line(-1);
    check("t4r_active", act_cnt, 80);
    check("t4r_ones", ones.size(), 24);
    check("t4r_restart", ones[8], 27);

    // vertical delay
    bus.copies = 2'd0;
    bus.scale = 2'd0;
    load_gfx(8'hF0, 0);
    swap_only();
    load_gfx(8'h0F, 0);
    bus.vdelay = 1'b1;
    run_line(-1);
    check("t5_old_first", ones[0], 11);
    check("t5_old_cnt", ones.size(), 4);
    bus.vdelay = 1'b0;
    run_line(-1);
    check("t5_new_first", ones[0], 15);
    load_gfx(8'h3C, 1);
    bus.vdelay = 1'b1;
    run_line(-1);
    check("t5_ls_first", ones[0], 15);
    bus.vdelay = 1'b0;
    run_line(-1);
    check("t5_ls_new", ones[0], 13);

    // reset mid-sprite, out-of-range position, strobe
    load_gfx(8'hFF, 0);
    for (int h = 0; h < 14; h++) begin
      cyc(1, h);
      if (h == 13) reset = 1'b1;
    end
    check("t6_mid_value", bus.value, 1);
    cyc(1, 14);
    check("t6_rst_value", bus.value, 0);
    check("t6_rst_active", bus.active, 0);
    set_pos(200);
    load_gfx(8'hFF, 0);
    run_line(-1);
    check("t6_pos_hold", ones[0], 1);
    run_line(40);
    run_line(-1);
    check("t6_strobe_first", ones[0], 41);
    check("t6_strobe_cnt", ones.size(), 8);

    repeat (3) cyc(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
